mult_operand_issue_taint: RTL and testbench
===========================================

MULT_OPERAND_ISSUE_TAINT -- requirements
Module: mult_operand_issue_taint

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width; SHALL equal the downstream multiplier WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-low; 0 at a rising clk edge resets all state.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream operand pair valid.
REQ-005 SHALL have port in_valid_t, input, 1 bit: taint of in_valid.
REQ-006 SHALL have port in_multiplier, input, WIDTH bits: multiplier operand.
REQ-007 SHALL have port in_multiplier_t, input, 1 bit: taint of the whole in_multiplier bus.
REQ-008 SHALL have port in_multiplicand, input, WIDTH bits: multiplicand operand.
REQ-009 SHALL have port in_multiplicand_t, input, 1 bit: taint of the whole in_multiplicand bus.
REQ-010 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-011 SHALL have port in_ready_t, output, 1 bit: taint of in_ready.
REQ-012 SHALL have port start, output, 1 bit: one-cycle start pulse to the multiplier.
REQ-013 SHALL have port start_t, output, 1 bit: taint of start.
REQ-014 SHALL have port multiplier, output, WIDTH bits: operand driven to the multiplier.
REQ-015 SHALL have port multiplier_t, output, 1 bit: taint of multiplier.
REQ-016 SHALL have port multiplicand, output, WIDTH bits: operand driven to the multiplier.
REQ-017 SHALL have port multiplicand_t, output, 1 bit: taint of multiplicand.
REQ-018 SHALL have port productDone, input, 1 bit: multiplier completion flag, level-held.
REQ-019 SHALL have port productDone_t, input, 1 bit: taint of productDone.
REQ-020 SHALL have port busy, output, 1 bit: an operation is issued and not yet complete.
REQ-021 SHALL have port busy_t, output, 1 bit: taint of busy.

Function
REQ-022 SHALL contain a 2-entry operand FIFO; each entry holds both operands plus both operand taint bits.
REQ-023 SHALL drive in_ready = 1 iff FIFO occupancy < 2; a push occurs iff in_valid & in_ready at a clock edge.
REQ-024 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; state encoding is free.
REQ-025 IDLE: SHALL go to ISSUE when FIFO is non-empty; otherwise SHALL stay in IDLE.
REQ-026 ISSUE: SHALL assert start for exactly this one cycle with the FIFO head on multiplier/multiplicand, SHALL pop the head at the cycle end, and SHALL go to WAIT.
REQ-027 SHALL latch the issued operands and their taints into output registers; outputs SHALL stay stable from the ISSUE cycle until the next ISSUE.
REQ-028 WAIT: SHALL go to IDLE only on a rising edge of productDone (registered previous value 0, current 1); a productDone held high from a prior operation SHALL NOT end WAIT.
REQ-029 busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE; start SHALL be 0 outside ISSUE.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-031 When the FIFO is full, in_ready SHALL be 0 and in_valid SHALL be ignored; a pop SHALL raise in_ready on the next cycle.
REQ-032 Minimum issue-to-issue spacing SHALL be 3 cycles after the productDone rising edge is sampled (WAIT -> IDLE -> ISSUE).
REQ-033 Taint register ctrl_t SHALL be sticky: set when a push occurs with in_valid_t = 1 or a WAIT exit occurs with productDone_t = 1; cleared only by reset.
REQ-034 start_t and busy_t SHALL equal ctrl_t.
REQ-035 Taint register occ_t SHALL be sticky: set on a push with in_valid_t = 1 or a pop with ctrl_t = 1; in_ready_t SHALL equal occ_t.
REQ-036 multiplier_t SHALL be the stored in_multiplier_t of the issued entry OR ctrl_t; multiplicand_t SHALL be the stored in_multiplicand_t OR ctrl_t.

Reset
REQ-037 On rst = 0 at a clock edge: state IDLE, FIFO empty, in_ready = 1, start = 0, busy = 0, operand outputs = 0, all _t outputs = 0, ctrl_t = occ_t = 0, productDone history = 0.
REQ-038 A reset mid-operation in any state SHALL discard FIFO contents and the in-flight operation, with no start pulse on the following cycle.

Verification
REQ-039 Bench SHALL cover: push (3,5), taints 0 -> start for 1 cycle with multiplier = 3, multiplicand = 5; busy = 1 until the productDone rise; all _t = 0.
REQ-040 Bench SHALL cover: three pushes back-to-back while WAIT with productDone held low -> third push sees in_ready = 0; pairs issue in order after each productDone rise.
REQ-041 Bench SHALL cover: productDone held at 1 across a new ISSUE -> stays in WAIT until productDone falls to 0 and rises again.
REQ-042 Bench SHALL cover: push with in_multiplier_t = 1 only -> multiplier_t = 1, multiplicand_t = 0, start_t = 0.
REQ-043 Bench SHALL cover: push with in_valid_t = 1 -> start_t, busy_t, in_ready_t = 1 and held until rst = 0.
REQ-044 Bench SHALL cover: rst = 0 during WAIT with 1 entry queued -> next cycle in_ready = 1, busy = 0, start = 0, all _t = 0.

Source files
------------

// File: rtl/mult_operand_issue_taint_if.sv
// Operand issue bus: upstream operand handshake, multiplier start/operands,
// multiplier completion, plus one taint bit per signal or bus.
interface mult_operand_issue_taint_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_valid_t;
  logic [WIDTH-1:0] in_multiplier;
  logic             in_multiplier_t;
  logic [WIDTH-1:0] in_multiplicand;
  logic             in_multiplicand_t;
  logic             in_ready;
  logic             in_ready_t;
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] multiplier;
  logic             multiplier_t;
  logic [WIDTH-1:0] multiplicand;
  logic             multiplicand_t;
  logic             productDone;
  logic             productDone_t;
  logic             busy;
  logic             busy_t;

  // Issue block side
  modport slave (
    input  in_valid, in_valid_t, in_multiplier, in_multiplier_t,
           in_multiplicand, in_multiplicand_t, productDone, productDone_t,
    output in_ready, in_ready_t, start, start_t, multiplier, multiplier_t,
           multiplicand, multiplicand_t, busy, busy_t
  );

  // Environment side (operand producer and multiplier)
  modport master (
    output in_valid, in_valid_t, in_multiplier, in_multiplier_t,
           in_multiplicand, in_multiplicand_t, productDone, productDone_t,
    input  in_ready, in_ready_t, start, start_t, multiplier, multiplier_t,
           multiplicand, multiplicand_t, busy, busy_t
  );
endinterface

// File: rtl/mult_operand_issue_taint.sv
// Operand issue stage for a multi-cycle multiplier. Operand pairs are queued
// in a 2-entry FIFO, issued one at a time with a single-cycle start pulse,
// and the next issue waits for a fresh rising edge of productDone.
// Control-path taint is tracked with sticky bits and merged into the outputs.
module mult_operand_issue_taint #(
  parameter int WIDTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  mult_operand_issue_taint_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // FIFO entry layout: {multiplicand_t, multiplier_t, multiplicand, multiplier}
  localparam int ENTRY_W = 2 * WIDTH + 2;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] fifo_q [0:1];
  logic [1:0]         count_q, count_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               pd_prev_q;
  logic               ctrl_t_q, ctrl_t_d;
  logic               occ_t_q, occ_t_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               mplier_t_q, mplier_t_d;
  logic               mcand_t_q, mcand_t_d;

  logic               in_ready_s;
  logic               push_s;
  logic               pop_s;
  logic               pd_rise_s;
  logic               wait_exit_s;
  logic               load_s;
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;

  assign in_ready_s  = (count_q < 2'd2);
  assign push_s      = bus.in_valid & in_ready_s;
  assign pop_s       = (state_q == ST_ISSUE);
  assign pd_rise_s   = bus.productDone & ~pd_prev_q;
  assign wait_exit_s = (state_q == ST_WAIT) & pd_rise_s;
  assign entry_s     = {bus.in_multiplicand_t, bus.in_multiplier_t,
                        bus.in_multiplicand, bus.in_multiplier};
  assign head_s      = fifo_q[rd_ptr_q];

  // Sequencer next state; start/busy are registered from the next state.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    busy_d  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != 2'd0) begin
          state_d = ST_ISSUE;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Only a fresh rise ends the wait; a level left high from an
        // earlier operation does not.
        if (pd_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

  // FIFO pointers and occupancy; push and pop together keep occupancy.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Output operand registers capture the FIFO head as the issue begins and
  // hold it until the following issue.
  always_comb begin
    mplier_d   = mplier_q;
    mcand_d    = mcand_q;
    mplier_t_d = mplier_t_q;
    mcand_t_d  = mcand_t_q;
    if (load_s) begin
      mplier_d   = head_s[WIDTH-1:0];
      mcand_d    = head_s[2*WIDTH-1:WIDTH];
      mplier_t_d = head_s[2*WIDTH];
      mcand_t_d  = head_s[2*WIDTH+1];
    end else begin
      mplier_d   = mplier_q;
      mcand_d    = mcand_q;
      mplier_t_d = mplier_t_q;
      mcand_t_d  = mcand_t_q;
    end
  end

  // Sticky control and occupancy taint.
  always_comb begin
    ctrl_t_d = ctrl_t_q | (push_s & bus.in_valid_t) |
               (wait_exit_s & bus.productDone_t);
    occ_t_d  = occ_t_q | (push_s & bus.in_valid_t) | (pop_s & ctrl_t_q);
  end

  // All state updates; synchronous active-low reset discards everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fifo_q[0]  <= {ENTRY_W{1'b0}};
      fifo_q[1]  <= {ENTRY_W{1'b0}};
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      pd_prev_q  <= 1'b0;
      ctrl_t_q   <= 1'b0;
      occ_t_q    <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      mplier_q   <= {WIDTH{1'b0}};
      mcand_q    <= {WIDTH{1'b0}};
      mplier_t_q <= 1'b0;
      mcand_t_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= entry_s;
      end
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pd_prev_q  <= bus.productDone;
      ctrl_t_q   <= ctrl_t_d;
      occ_t_q    <= occ_t_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      mplier_q   <= mplier_d;
      mcand_q    <= mcand_d;
      mplier_t_q <= mplier_t_d;
      mcand_t_q  <= mcand_t_d;
    end
  end

  assign bus.in_ready       = in_ready_s;
  assign bus.in_ready_t     = occ_t_q;
  assign bus.start          = start_q;
  assign bus.start_t        = ctrl_t_q;
  assign bus.busy           = busy_q;
  assign bus.busy_t         = ctrl_t_q;
  assign bus.multiplier     = mplier_q;
  assign bus.multiplier_t   = mplier_t_q | ctrl_t_q;
  assign bus.multiplicand   = mcand_q;
  assign bus.multiplicand_t = mcand_t_q | ctrl_t_q;

endmodule

// File: tb/tb_mult_operand_issue_taint.sv
// Directed and randomized bench for mult_operand_issue_taint. A queue-based
// reference model predicts every output each cycle.
module tb_mult_operand_issue_taint;

  localparam int W = 4;

  logic clk;
  logic rst;

  mult_operand_issue_taint_if #(.WIDTH(W)) bus_if ();

  mult_operand_issue_taint #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         at;
    logic         bt;
  } pair_t;

  // Reference model: queued pairs, "an op is outstanding", "issuing now".
  pair_t        mq[$];
  logic         m_start, m_busy, m_ctrl_t, m_occ_t, m_pd_prev;
  logic [W-1:0] m_a, m_b;
  logic         m_at, m_bt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic  acc, new_ctrl, new_occ;
    pair_t np;
    if (!rst) begin
      mq.delete();
      m_start = 1'b0; m_busy = 1'b0; m_ctrl_t = 1'b0; m_occ_t = 1'b0;
      m_a = '0; m_b = '0; m_at = 1'b0; m_bt = 1'b0;
      m_pd_prev = 1'b0;
    end else begin
      acc      = bus_if.in_valid && (mq.size() < 2);
      new_ctrl = m_ctrl_t | (acc & bus_if.in_valid_t);
      new_occ  = m_occ_t | (acc & bus_if.in_valid_t) | (m_start & m_ctrl_t);
      if (m_start) begin
        void'(mq.pop_front());
        m_start = 1'b0;
      end else if (m_busy) begin
        if (bus_if.productDone && !m_pd_prev) begin
          m_busy   = 1'b0;
          new_ctrl = new_ctrl | bus_if.productDone_t;
        end
      end else if (mq.size() > 0) begin
        m_start = 1'b1;
        m_busy  = 1'b1;
        m_a = mq[0].a; m_b = mq[0].b; m_at = mq[0].at; m_bt = mq[0].bt;
      end
      if (acc) begin
        np.a = bus_if.in_multiplier; np.b = bus_if.in_multiplicand;
        np.at = bus_if.in_multiplier_t; np.bt = bus_if.in_multiplicand_t;
        mq.push_back(np);
      end
      m_ctrl_t  = new_ctrl;
      m_occ_t   = new_occ;
      m_pd_prev = bus_if.productDone;
    end
  endtask

  task automatic check_all();
    check("in_ready",       8'(bus_if.in_ready),       8'(mq.size() < 2));
    check("in_ready_t",     8'(bus_if.in_ready_t),     8'(m_occ_t));
    check("start",          8'(bus_if.start),          8'(m_start));
    check("start_t",        8'(bus_if.start_t),        8'(m_ctrl_t));
    check("busy",           8'(bus_if.busy),           8'(m_busy));
    check("busy_t",         8'(bus_if.busy_t),         8'(m_ctrl_t));
    check("multiplier",     8'(bus_if.multiplier),     8'(m_a));
    check("multiplier_t",   8'(bus_if.multiplier_t),   8'(m_at | m_ctrl_t));
    check("multiplicand",   8'(bus_if.multiplicand),   8'(m_b));
    check("multiplicand_t", 8'(bus_if.multiplicand_t), 8'(m_bt | m_ctrl_t));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push(input int a, input int b, input logic vt, input logic at, input logic bt);
    bus_if.in_valid          = 1'b1;
    bus_if.in_valid_t        = vt;
    bus_if.in_multiplier     = W'(a);
    bus_if.in_multiplicand   = W'(b);
    bus_if.in_multiplier_t   = at;
    bus_if.in_multiplicand_t = bt;
    cycle();
    bus_if.in_valid          = 1'b0;
    bus_if.in_valid_t        = 1'b0;
    bus_if.in_multiplier_t   = 1'b0;
    bus_if.in_multiplicand_t = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (bus_if.start === 1'b1) break;
      cycle();
    end
    check(tag, 8'(bus_if.start), 8'd1);
  endtask

  task automatic pd_pulse();
    bus_if.productDone = 1'b1;
    cycle();
    bus_if.productDone = 1'b0;
  endtask

  initial begin
    int exp_a[2];
    rst = 1'b0;
    bus_if.in_valid = 1'b0; bus_if.in_valid_t = 1'b0;
    bus_if.in_multiplier = '0; bus_if.in_multiplier_t = 1'b0;
    bus_if.in_multiplicand = '0; bus_if.in_multiplicand_t = 1'b0;
    bus_if.productDone = 1'b0; bus_if.productDone_t = 1'b0;

    // Reset state
    cycle(); cycle();
    rst = 1'b1;
    check("rst_in_ready", 8'(bus_if.in_ready), 8'd1);
    check("rst_busy", 8'(bus_if.busy), 8'd0);
    check("rst_start", 8'(bus_if.start), 8'd0);
    check("rst_mult", 8'(bus_if.multiplier), 8'd0);
    cycle();

    // Single operation (3,5), clean taints
    push(3, 5, 1'b0, 1'b0, 1'b0);
    wait_start("t039_start_seen");
    check("t039_mplier", 8'(bus_if.multiplier), 8'd3);
    check("t039_mcand", 8'(bus_if.multiplicand), 8'd5);
    check("t039_start_t", 8'(bus_if.start_t), 8'd0);
    check("t039_mplier_t", 8'(bus_if.multiplier_t), 8'd0);
    cycle();
    check("t039_start_1cyc", 8'(bus_if.start), 8'd0);
    check("t039_busy_wait", 8'(bus_if.busy), 8'd1);
    repeat (3) cycle();
    pd_pulse();
    check("t039_busy_done", 8'(bus_if.busy), 8'd0);
    cycle();

    // Fill the FIFO while waiting; issue order follows push order
    push(1, 2, 1'b0, 1'b0, 1'b0);
    wait_start("t040_first_start");
    cycle();
    push(4, 6, 1'b0, 1'b0, 1'b0);
    push(7, 8, 1'b0, 1'b0, 1'b0);
    check("t040_full_ready", 8'(bus_if.in_ready), 8'd0);
    push(9, 10, 1'b0, 1'b0, 1'b0);
    exp_a[0] = 4; exp_a[1] = 7;
    for (int k = 0; k < 2; k++) begin
      repeat (2) cycle();
      pd_pulse();
      wait_start("t040_next_start");
      check("t040_order", 8'(bus_if.multiplier), 8'(exp_a[k]));
      cycle();
    end
    pd_pulse();
    cycle();
    check("t040_drained_busy", 8'(bus_if.busy), 8'd0);
    check("t040_drained_ready", 8'(bus_if.in_ready), 8'd1);

    // productDone held high across a new issue
    push(11, 12, 1'b0, 1'b0, 1'b0);
    wait_start("t041_start_a");
    cycle();
    push(13, 14, 1'b0, 1'b0, 1'b0);
    bus_if.productDone = 1'b1;
    cycle();
    wait_start("t041_start_b");
    check("t041_mplier", 8'(bus_if.multiplier), 8'd13);
    repeat (5) cycle();
    check("t041_hold_busy", 8'(bus_if.busy), 8'd1);
    bus_if.productDone = 1'b0;
    cycle();
    check("t041_low_busy", 8'(bus_if.busy), 8'd1);
    bus_if.productDone = 1'b1;
    cycle();
    check("t041_rise_done", 8'(bus_if.busy), 8'd0);
    bus_if.productDone = 1'b0;
    cycle();

    // Operand taint only
    push(2, 9, 1'b0, 1'b1, 1'b0);
    wait_start("t042_start");
    check("t042_mplier_t", 8'(bus_if.multiplier_t), 8'd1);
    check("t042_mcand_t", 8'(bus_if.multiplicand_t), 8'd0);
    check("t042_start_t", 8'(bus_if.start_t), 8'd0);
    cycle();
    pd_pulse();
    cycle();

    // Control taint is sticky until reset
    push(5, 6, 1'b1, 1'b0, 1'b0);
    check("t043_busy_t", 8'(bus_if.busy_t), 8'd1);
    check("t043_ready_t", 8'(bus_if.in_ready_t), 8'd1);
    wait_start("t043_start");
    check("t043_start_t", 8'(bus_if.start_t), 8'd1);
    cycle();
    pd_pulse();
    repeat (5) cycle();
    check("t043_held_busy_t", 8'(bus_if.busy_t), 8'd1);
    check("t043_held_ready_t", 8'(bus_if.in_ready_t), 8'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("t043_rst_start_t", 8'(bus_if.start_t), 8'd0);

    // Reset during WAIT with one entry queued
    push(1, 1, 1'b0, 1'b1, 1'b1);
    wait_start("t044_start");
    cycle();
    push(2, 2, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("t044_ready", 8'(bus_if.in_ready), 8'd1);
    check("t044_busy", 8'(bus_if.busy), 8'd0);
    check("t044_start", 8'(bus_if.start), 8'd0);
    check("t044_mplier_t", 8'(bus_if.multiplier_t), 8'd0);
    check("t044_ready_t", 8'(bus_if.in_ready_t), 8'd0);
    cycle();
    check("t044_no_start", 8'(bus_if.start), 8'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus_if.in_valid          = 1'($urandom_range(0, 1));
      bus_if.in_valid_t        = ($urandom_range(0, 31) == 0);
      bus_if.in_multiplier     = W'($urandom);
      bus_if.in_multiplicand   = W'($urandom);
      bus_if.in_multiplier_t   = ($urandom_range(0, 7) == 0);
      bus_if.in_multiplicand_t = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) bus_if.productDone = ~bus_if.productDone;
      bus_if.productDone_t     = ($urandom_range(0, 31) == 0);
      rst                      = ($urandom_range(0, 79) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
